// File: rtl/wb_queue.sv
// wb_queue: pending register-file write queue with optional forwarding.
// Writes are accepted from a producer, held in FIFO order and retired to
// the regfile write port (we3/wa3/wd3) whenever the port is not stalled.
// Writes to x0 are handshaken and dropped.
// Optional feature: define WB_QUEUE_BYPASS_EN to build the two forwarding
// query ports (qa1/qa2 -> qhit/qd). Without it the query outputs are zero.

`ifdef WB_QUEUE_BYPASS_EN
// Per-entry forwarding comparator: one instance per queue slot.
module wb_queue_lane (
  input  logic       occ,
  input  logic [4:0] addr,
  input  logic [4:0] qa1,
  input  logic [4:0] qa2,
  output logic       hit1,
  output logic       hit2
);
  // Slot matches a query when occupied and addressed to the same nonzero reg.
  always_comb begin
    hit1 = occ && (qa1 != 5'd0) && (addr == qa1);
    hit2 = occ && (qa2 != 5'd0) && (addr == qa2);
  end
endmodule
`endif

module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_addr,
  input  logic [31:0]                in_data,
  input  logic                       wb_stall,
  output logic                       we3,
  output logic [4:0]                 wa3,
  output logic [31:0]                wd3,
  input  logic [4:0]                 qa1,
  input  logic [4:0]                 qa2,
  output logic                       qhit1,
  output logic                       qhit2,
  output logic [31:0]                qd1,
  output logic [31:0]                qd2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t [DEPTH-1:0] mem;
  logic [AW-1:0]       head, tail;
  logic                push, pop;

  // Flow control: accept whenever not full, retire head whenever port is free.
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    in_ready = !full;
    push     = in_valid && in_ready && (in_addr != 5'd0);
    pop      = !empty && !wb_stall;
  end

  // Regfile write port: head is presented combinationally so it is captured
  // on the same edge that pops it. Zeroed when nothing is pending.
  always_comb begin
    we3 = pop;
    wa3 = '0;
    wd3 = '0;
    if (!empty) begin
      wa3 = mem[head].addr;
      wd3 = mem[head].data;
    end
  end

  // Pointers and occupancy; reset drops every pending entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage is not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{addr: in_addr, data: in_data};
  end

`ifdef WB_QUEUE_BYPASS_EN
  logic [DEPTH-1:0] occ, hit1, hit2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_lane
      logic [AW-1:0] age;
      // Age of the slot relative to head; slot is live if younger than count.
      always_comb begin
        age     = AW'(gi) - head;
        occ[gi] = (CW'(age) < count);
      end
      wb_queue_lane u_lane (
        .occ  (occ[gi]),
        .addr (mem[gi].addr),
        .qa1  (qa1),
        .qa2  (qa2),
        .hit1 (hit1[gi]),
        .hit2 (hit2[gi])
      );
    end
  endgenerate

  // Walk slots oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [AW-1:0] idx;
    qhit1 = |hit1;
    qhit2 = |hit2;
    qd1   = '0;
    qd2   = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (hit1[idx]) qd1 = mem[idx].data;
      if (hit2[idx]) qd2 = mem[idx].data;
    end
  end
`else
  logic unused_query;

  // Forwarding not built: query addresses are ignored.
  always_comb begin
    unused_query = ^{qa1, qa2};
    qhit1 = 1'b0;
    qhit2 = 1'b0;
    qd1   = '0;
    qd2   = '0;
  end
`endif

endmodule
